morse_timing_ctrl: RTL and testbench
====================================

Name: morse_timing_ctrl

Overview:
Sequences a unit-length countdown timer to time key-down (mark) and key-up (space) intervals on the Morse key input. On key release it classifies the mark as a DOT or a DASH. While the key is up it flags letter and word boundaries. It delivers these events to the downstream symbol decoder over a valid/ready handshake. It sits between the debounced key input and the character decoder.

Parameters:
UNIT_TICKS, 10_000_000, length of one timing unit in clk_100Mhz cycles (100 ms); passed as TICK_COUNT to the timer instance.
DASH_MIN_UNITS, 2, completed mark units at or above which a mark is a DASH.
LETTER_GAP_UNITS, 2, completed space units at which LETTER_END is raised.
WORD_GAP_UNITS, 5, completed space units at which WORD_END is raised; must be greater than LETTER_GAP_UNITS.

Ports:
clk_100Mhz  in  1  system clock, 100 MHz.
reset  in  1  synchronous, active-high reset.
key_in  in  1  key level, 1 = pressed; already synchronised and debounced upstream.
evt_ready  in  1  downstream accepts the event when evt_valid && evt_ready.
evt_valid  out  1  event pending.
evt_code  out  2  event type, morse_pkg::evt_t.
overrun  out  1  sticky flag: an event was dropped because the previous one was unaccepted.

Behaviour:
- Reset values: evt_valid=0, evt_code=EVT_DOT, overrun=0, state=IDLE, unit count=0, key_q=0.
- Edge detection
  - key_q registers key_in each cycle.
  - rise = key_in & ~key_q; fall = ~key_in & key_q.
  - A key held through reset produces a rise in the first cycle after reset.
- Timer control
  - Internal tmr_rst (combinational) drives the timer's synchronous reset.
  - It is asserted on any rise, any fall, and on every cycle where time_out=1 while in MARK or SPACE.
  - This gives a unit period of exactly UNIT_TICKS cycles.
  - In IDLE the timer is left free and time_out is ignored.
- Unit counter
  - Reset to 0 on rise and on fall.
  - Increments when time_out=1 in MARK or SPACE, with no edge in the same cycle.
  - Saturates at WORD_GAP_UNITS; width is $clog2(WORD_GAP_UNITS+1).
- Edge priority: an edge and a time_out in the same cycle resolve to the edge; the timeout is discarded.
- States
  - IDLE: key up, no gap timing. Rise -> MARK.
  - MARK: fall -> SPACE and generate an event. The event is DASH if units >= DASH_MIN_UNITS, else DOT. A mark shorter than one unit is a DOT.
  - SPACE
    - Rise -> MARK.
    - Units reaching LETTER_GAP_UNITS: generate LETTER_END once.
    - Units reaching WORD_GAP_UNITS: generate WORD_END once, then -> IDLE.
  - No LETTER_END or WORD_END is ever raised before the first mark after reset.
- Mark classification: for key high L cycles, completed units = floor((L-1)/UNIT_TICKS).
- Event output (registered)
  - A generated event appears on evt_valid/evt_code the cycle after the generating edge or threshold cycle.
  - evt_valid and evt_code hold until evt_valid && evt_ready.
  - If a new event is generated while one is still pending and not accepted that same cycle: the new event is dropped, overrun is set, and the pending event is kept.
  - Accept and generate in the same cycle: the new event replaces the old one, and overrun is unchanged.
  - overrun is cleared only by reset.
- Reset mid-operation: all state, the pending event and overrun are cleared immediately; no partial event is emitted.

Decomposition:
- morse_pkg
  - typedef enum logic [1:0] evt_t {EVT_DOT=0, EVT_DASH=1, EVT_LETTER=2, EVT_WORD=3}
  - typedef enum state_t {IDLE, MARK, SPACE}
- One sub-module: countdown_timer, instantiated with TICK_COUNT=UNIT_TICKS.
  - Sync reset reloads TICK_COUNT-1.
  - time_out is high while the count is 0.
  - Clock and reset are clk_100Mhz and tmr_rst.

Test Plan:
(all tests: UNIT_TICKS=4, defaults otherwise, evt_ready=1 unless stated)
- Key high 8 cycles -> units=1 -> single EVT_DOT, evt_valid pulses for 1 cycle, 1 cycle after the fall cycle.
- Key high 9 cycles -> units=2 -> EVT_DASH (DASH_MIN boundary); key high 14 cycles -> EVT_DASH.
- DOT then key up indefinitely, fall at cycle f:
  - EVT_LETTER valid at f+9, EVT_WORD valid at f+21.
  - State IDLE afterwards, no further events for 100 cycles.
- Key released from reset for 100 cycles -> no events.
- Gap broken by a rise at f+6 -> no LETTER_END; the next mark is timed from its own rise.
- evt_ready=0: DOT then DASH -> DOT held on the outputs, overrun=1, DASH lost.
  - Then evt_ready=1 -> DOT accepted, evt_valid=0.
  - reset -> overrun=0.
- Reset asserted mid-mark (key still high) for 1 cycle:
  - No event for the aborted mark.
  - The first cycle after reset sees a rise; releasing after 5 cycles yields EVT_DOT.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types for the Morse key timing path: event codes sent downstream
// and the key-timing controller states.
package morse_pkg;

  typedef enum logic [1:0] {
    EVT_DOT    = 2'd0,
    EVT_DASH   = 2'd1,
    EVT_LETTER = 2'd2,
    EVT_WORD   = 2'd3
  } evt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Free-running unit timer: counts TICK_COUNT-1 down to 0 and wraps, so one
// period is exactly TICK_COUNT cycles; time_out flags the zero cycle.
module countdown_timer #(
  parameter int TICK_COUNT = 10_000_000
) (
  input  logic clk_100Mhz,
  input  logic tmr_rst,
  output logic time_out
);

  localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_COUNT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk_100Mhz) begin
    if (tmr_rst) begin
      r_count <= RELOAD;
    end else if (r_count == '0) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - CW'(1);
    end
  end

  assign time_out = (r_count == '0);

endmodule

// File: rtl/morse_timing_ctrl.sv
// Times key-down/key-up intervals in whole units, classifies marks as DOT or
// DASH, flags letter/word gaps, and hands events downstream over valid/ready.
module morse_timing_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_TICKS       = 10_000_000,
  parameter int DASH_MIN_UNITS   = 2,
  parameter int LETTER_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS   = 5
) (
  input  logic clk_100Mhz,
  input  logic reset,
  input  logic key_in,
  input  logic evt_ready,
  output logic evt_valid,
  output evt_t evt_code,
  output logic overrun
);

  localparam int UW = $clog2(WORD_GAP_UNITS + 1);

  state_t        r_state;
  state_t        w_nextState;
  logic          r_keyQ;
  logic [UW-1:0] r_units;
  logic [UW-1:0] w_unitsInc;
  logic          w_rise;
  logic          w_fall;
  logic          w_timeOut;
  logic          w_tick;
  logic          w_tmrRst;
  logic          w_letterHit;
  logic          w_wordHit;
  logic          w_gen;
  evt_t          w_genCode;
  logic          r_evtValid;
  evt_t          r_evtCode;
  logic          r_overrun;

  assign w_rise = key_in & ~r_keyQ;
  assign w_fall = ~key_in & r_keyQ;

  // An edge in the same cycle as a timeout wins; that timeout is discarded.
  assign w_tick   = w_timeOut && (r_state != IDLE) && !w_rise && !w_fall;
  assign w_tmrRst = reset | w_rise | w_fall | (w_timeOut && (r_state != IDLE));

  assign w_unitsInc  = (r_units == UW'(WORD_GAP_UNITS)) ? r_units : r_units + UW'(1);
  assign w_letterHit = w_tick && (r_state == SPACE) && (r_units == UW'(LETTER_GAP_UNITS - 1));
  assign w_wordHit   = w_tick && (r_state == SPACE) && (r_units == UW'(WORD_GAP_UNITS - 1));

  countdown_timer #(
    .TICK_COUNT(UNIT_TICKS)
  ) u_timer (
    .clk_100Mhz(clk_100Mhz),
    .tmr_rst   (w_tmrRst),
    .time_out  (w_timeOut)
  );

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      r_keyQ  <= 1'b0;
      r_units <= '0;
    end else begin
      r_keyQ <= key_in;
      if (w_rise || w_fall) begin
        r_units <= '0;
      end else if (w_tick) begin
        r_units <= w_unitsInc;
      end
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_nextState = MARK;
      MARK:    if (w_fall) w_nextState = SPACE;
      SPACE: begin
        if (w_rise) begin
          w_nextState = MARK;
        end else if (w_wordHit) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_gen     = 1'b0;
    w_genCode = EVT_DOT;
    case (r_state)
      MARK: begin
        if (w_fall) begin
          w_gen     = 1'b1;
          w_genCode = (r_units >= UW'(DASH_MIN_UNITS)) ? EVT_DASH : EVT_DOT;
        end
      end
      SPACE: begin
        if (w_letterHit) begin
          w_gen     = 1'b1;
          w_genCode = EVT_LETTER;
        end else if (w_wordHit) begin
          w_gen     = 1'b1;
          w_genCode = EVT_WORD;
        end
      end
      default: begin
        w_gen     = 1'b0;
        w_genCode = EVT_DOT;
      end
    endcase
  end

  // A new event may only overwrite the pending one if it is accepted this cycle.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      r_evtValid <= 1'b0;
      r_evtCode  <= EVT_DOT;
      r_overrun  <= 1'b0;
    end else if (w_gen) begin
      if (!r_evtValid || evt_ready) begin
        r_evtValid <= 1'b1;
        r_evtCode  <= w_genCode;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_evtValid && evt_ready) begin
      r_evtValid <= 1'b0;
    end
  end

  assign evt_valid = r_evtValid;
  assign evt_code  = r_evtCode;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_morse_timing_ctrl.sv
// Bench for morse_timing_ctrl with a 4-cycle unit: directed scenarios then
// random key/ready traffic, all checked against a cycle-count reference model.
module tb_morse_timing_ctrl;
  import morse_pkg::*;

  localparam int UNIT   = 4;
  localparam int DMIN   = 2;
  localparam int LETTER = 2;
  localparam int WORD   = 5;

  logic clk = 1'b0;
  logic reset;
  logic key_in;
  logic evt_ready;
  logic evt_valid;
  evt_t evt_code;
  logic overrun;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  logic       mPrev;
  int         mMarkLen;
  int         mGapLen;
  logic       mPendV;
  logic [1:0] mPendC;
  logic       mOvr;

  always #5 clk = ~clk;

  morse_timing_ctrl #(
    .UNIT_TICKS      (UNIT),
    .DASH_MIN_UNITS  (DMIN),
    .LETTER_GAP_UNITS(LETTER),
    .WORD_GAP_UNITS  (WORD)
  ) dut (
    .clk_100Mhz(clk),
    .reset     (reset),
    .key_in    (key_in),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model works from mark length and cycles since release, not from units.
  task automatic applyStimulus(input logic k, input logic rdy, input logic rst);
    logic       gen;
    logic [1:0] code;
    @(negedge clk);
    key_in    = k;
    evt_ready = rdy;
    reset     = rst;
    gen       = 1'b0;
    code      = EVT_DOT;
    if (rst) begin
      mPrev    = 1'b0;
      mMarkLen = 0;
      mGapLen  = -1;
      mPendV   = 1'b0;
      mPendC   = EVT_DOT;
      mOvr     = 1'b0;
    end else begin
      if (k && !mPrev) begin
        mMarkLen = 1;
        mGapLen  = -1;
      end else if (k) begin
        mMarkLen++;
      end else if (mPrev) begin
        gen     = 1'b1;
        code    = (((mMarkLen - 1) / UNIT) >= DMIN) ? EVT_DASH : EVT_DOT;
        mGapLen = 0;
      end else if (mGapLen >= 0) begin
        mGapLen++;
        if (mGapLen == LETTER * UNIT) begin
          gen  = 1'b1;
          code = EVT_LETTER;
        end else if (mGapLen == WORD * UNIT) begin
          gen     = 1'b1;
          code    = EVT_WORD;
          mGapLen = -1;
        end
      end
      if (gen) begin
        if (!mPendV || rdy) begin
          mPendV = 1'b1;
          mPendC = code;
        end else begin
          mOvr = 1'b1;
        end
      end else if (mPendV && rdy) begin
        mPendV = 1'b0;
      end
      mPrev = k;
    end
    cycle++;
    @(posedge clk);
    #1;
    checkOutput($sformatf("valid@%0d", cycle), {1'b0, evt_valid}, {1'b0, mPendV});
    checkOutput($sformatf("code@%0d", cycle), evt_code, mPendC);
    checkOutput($sformatf("overrun@%0d", cycle), {1'b0, overrun}, {1'b0, mOvr});
  endtask

  initial begin
    int markCycles;
    int gapCycles;
    logic rdyBit;
    reset     = 1'b1;
    key_in    = 1'b0;
    evt_ready = 1'b1;
    mPrev     = 1'b0;
    mMarkLen  = 0;
    mGapLen   = -1;
    mPendV    = 1'b0;
    mPendC    = EVT_DOT;
    mOvr      = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rstValid", {1'b0, evt_valid}, 2'd0);
    checkOutput("rstCode", evt_code, EVT_DOT);
    checkOutput("rstOverrun", {1'b0, overrun}, 2'd0);

    repeat (100) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("idleQuiet", {1'b0, evt_valid}, 2'd0);

    // DOT (8 high) then letter at f+9 and word at f+21
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dot8Valid", {1'b0, evt_valid}, 2'd1);
    checkOutput("dot8Code", evt_code, EVT_DOT);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dot8Pulse", {1'b0, evt_valid}, 2'd0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("letterValid", {1'b0, evt_valid}, 2'd1);
    checkOutput("letterCode", evt_code, EVT_LETTER);
    repeat (11) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("wordValid", {1'b0, evt_valid}, 2'd1);
    checkOutput("wordCode", evt_code, EVT_WORD);
    repeat (100) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("postWordQuiet", {1'b0, evt_valid}, 2'd0);

    // DASH boundary at 9 high, then a 14-high DASH
    repeat (9) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dash9Code", evt_code, EVT_DASH);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (14) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dash14Valid", {1'b0, evt_valid}, 2'd1);
    checkOutput("dash14Code", evt_code, EVT_DASH);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b0);

    // Gap broken by a rise at f+6, next mark of 5 cycles is a DOT
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("noLetter", {1'b0, evt_valid}, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("retimedDot", evt_code, EVT_DOT);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b0);

    // Back-pressure: DOT held, DASH dropped, overrun sticky until reset
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("heldValid", {1'b0, evt_valid}, 2'd1);
    checkOutput("heldCode", evt_code, EVT_DOT);
    checkOutput("overrunSet", {1'b0, overrun}, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("acceptedValid", {1'b0, evt_valid}, 2'd0);
    checkOutput("overrunSticky", {1'b0, overrun}, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("overrunCleared", {1'b0, overrun}, 2'd0);
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);

    // Reset mid-mark with key held: aborted mark is silent, new rise follows
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("abortValid", {1'b0, evt_valid}, 2'd0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("postRstValid", {1'b0, evt_valid}, 2'd1);
    checkOutput("postRstCode", evt_code, EVT_DOT);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b0);

    for (int seg = 0; seg < 60; seg++) begin
      markCycles = $urandom_range(1, 30);
      gapCycles  = $urandom_range(1, 30);
      if ($urandom_range(0, 19) == 0) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      end
      for (int i = 0; i < markCycles; i++) begin
        rdyBit = ($urandom_range(0, 3) != 0);
        applyStimulus(1'b1, rdyBit, 1'b0);
      end
      for (int i = 0; i < gapCycles; i++) begin
        rdyBit = ($urandom_range(0, 3) != 0);
        applyStimulus(1'b0, rdyBit, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
